led_source_ctrl: RTL and testbench

- Control stage directly upstream of the LED/7-segment VGA display block; drives its red_leds, green_leds and segments inputs.
- Replaces a free-running binary counter with a debounced run/pause and clear key pair and an 8-digit BCD stopwatch-style counter.
- Also produces a walking-LED pattern and a digit-0 bar graph.
- Runs entirely in the video clock domain.

---
 rtl/led_src_pkg.sv | 22 ++
 rtl/led_source_ctrl_if.sv | 29 ++
 rtl/key_debounce.sv | 51 +++++
 rtl/led_source_ctrl.sv | 125 ++++++++++++
 tb/tb_led_source_ctrl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/led_src_pkg.sv
// Shared types, constants and decode helpers for the LED source controller.
package led_src_pkg;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_e;

  localparam int unsigned NUM_DIGITS = 8;
  localparam logic [15:0] WALK_INIT  = 16'h0001;

  // Digit value d lights bits d-1..0; values above 9 saturate to all nine bits.
  function automatic logic [8:0] therm_decode(input logic [3:0] d);
    logic [8:0] t;
    t = '0;
    for (int i = 0; i < 9; i++) begin
      if (4'(i) < d) t[i] = 1'b1;
    end
    return t;
  endfunction

endpackage

// File: rtl/led_source_ctrl_if.sv
// Key inputs and display-facing outputs of the LED source controller.
interface led_source_ctrl_if;
  logic        key_run_n;
  logic        key_clr_n;
  logic [15:0] red_leds;
  logic [15:0] green_leds;
  logic [31:0] segments;
  logic        running;

  // Controller side: samples keys, drives display inputs.
  modport master (
    input  key_run_n,
    input  key_clr_n,
    output red_leds,
    output green_leds,
    output segments,
    output running
  );

  // Key/display side.
  modport slave (
    output key_run_n,
    output key_clr_n,
    input  red_leds,
    input  green_leds,
    input  segments,
    input  running
  );
endinterface

// File: rtl/key_debounce.sv
// Synchronizes a raw active-low key, debounces it and emits a one-cycle press pulse.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 740000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_ni,
  output logic press_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]      sync_q, sync_d;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            press_q, press_d;

  // Next-state: shift synchronizer, count while the stable level disagrees.
  always_comb begin
    sync_d  = {sync_q[0], key_ni};
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
    // Only the released-to-pressed transition is an event.
    press_d = level_q & ~level_d;
  end

  // State registers; keys read as released out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/led_source_ctrl.sv
// Run/pause stopwatch with 8-digit BCD count, walking LED and digit-0 bar graph.
module led_source_ctrl
  import led_src_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 740000,
  parameter int unsigned TICK_DIV        = 7400000
) (
  input  logic               clk_video,
  input  logic               reset,
  led_source_ctrl_if.master  bus
);

  localparam int unsigned PscW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic run_press, clr_press;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_run_key (
    .clk_i  (clk_video),
    .rst_i  (reset),
    .key_ni (bus.key_run_n),
    .press_o(run_press)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_clr_key (
    .clk_i  (clk_video),
    .rst_i  (reset),
    .key_ni (bus.key_clr_n),
    .press_o(clr_press)
  );

  state_e          state_q, state_d;
  logic [PscW-1:0] psc_q, psc_d;
  logic [31:0]     seg_q, seg_d;
  logic [15:0]     red_q, red_d;
  logic [15:0]     green_q, green_d;
  logic            wrap_q, wrap_d;

  logic            tick;
  logic [31:0]     seg_inc;
  logic            seg_carry;

  // BCD increment with ripple carry; a carry out of the top digit means 99999999 -> 0.
  always_comb begin
    seg_inc   = seg_q;
    seg_carry = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (seg_carry) begin
        if (seg_q[4*k +: 4] == 4'd9) begin
          seg_inc[4*k +: 4] = 4'd0;
        end else begin
          seg_inc[4*k +: 4] = seg_q[4*k +: 4] + 4'd1;
          seg_carry         = 1'b0;
        end
      end
    end
  end

  // FSM next state, prescaler, counter, walk pattern and status; clear overrides a tick.
  always_comb begin
    state_d = state_q;
    psc_d   = psc_q;
    seg_d   = seg_q;
    red_d   = red_q;
    wrap_d  = wrap_q;
    tick    = 1'b0;

    if (run_press) begin
      state_d = (state_q == RUNNING) ? STOPPED : RUNNING;
    end

    // Prescaler holds while stopped so a partial tick survives pause/resume.
    if (state_q == RUNNING) begin
      if (psc_q == PscW'(TICK_DIV - 1)) begin
        psc_d = '0;
        tick  = 1'b1;
      end else begin
        psc_d = psc_q + PscW'(1);
      end
    end

    if (tick) begin
      seg_d = seg_inc;
      red_d = {red_q[14:0], red_q[15]};
      if (seg_carry) wrap_d = 1'b1;
    end

    if (clr_press) begin
      seg_d  = '0;
      psc_d  = '0;
      red_d  = WALK_INIT;
      wrap_d = 1'b0;
    end

    green_d = {state_q == RUNNING, wrap_q, 5'b0, therm_decode(seg_q[3:0])};
  end

  // State and output registers.
  always_ff @(posedge clk_video or posedge reset) begin
    if (reset) begin
      state_q <= STOPPED;
      psc_q   <= '0;
      seg_q   <= '0;
      red_q   <= WALK_INIT;
      green_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      psc_q   <= psc_d;
      seg_q   <= seg_d;
      red_q   <= red_d;
      green_q <= green_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.segments   = seg_q;
  assign bus.red_leds   = red_q;
  assign bus.green_leds = green_q;
  assign bus.running    = (state_q == RUNNING);

endmodule

// File: tb/tb_led_source_ctrl.sv
// Scenario bench for led_source_ctrl with DEBOUNCE_CYCLES=4, TICK_DIV=3.
module tb_led_source_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  led_source_ctrl_if bus ();

  led_source_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .TICK_DIV       (3)
  ) dut (
    .clk_video(clk),
    .reset    (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  function automatic void sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endfunction

  task automatic sb_check(input logic [31:0] obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_total++;
      n_bad++;
      $display("FAIL sb_underflow: got %08h want none", obs);
    end else begin
      e = exp_q.pop_front();
      check_val(e.tag, obs, e.val);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.key_run_n = 1'b1;
    bus.key_clr_n = 1'b1;
    step(3);
    rst = 1'b0;

    // Reset state.
    sb_push("rst_seg", 32'h0);
    sb_push("rst_red", 32'h0001);
    sb_push("rst_green", 32'h0);
    sb_push("rst_run", 32'h0);
    sb_check(bus.segments);
    sb_check(32'(bus.red_leds));
    sb_check(32'(bus.green_leds));
    sb_check(32'(bus.running));

    // Bounces shorter than the debounce window never produce a press.
    for (int i = 0; i < 3; i++) begin
      bus.key_run_n = 1'b0;
      step(3);
      bus.key_run_n = 1'b1;
      step(3);
    end
    sb_push("bounce_run", 32'h0);
    sb_push("bounce_seg", 32'h0);
    step(10);
    sb_check(32'(bus.running));
    sb_check(bus.segments);

    // Held press: running on the 7th edge, first tick 3 edges later.
    bus.key_run_n = 1'b0;
    sb_push("run_early", 32'h0);
    sb_push("run_on", 32'h1);
    sb_push("first_tick", 32'h1);
    step(6);
    sb_check(32'(bus.running));
    step(1);
    sb_check(32'(bus.running));
    step(3);
    sb_check(bus.segments);
    bus.key_run_n = 1'b1;

    // 30 ticks total.
    sb_push("seg_30", 32'h30);
    sb_push("red_30", 32'h4000);
    sb_push("green_30", 32'h8000);
    step(87);
    sb_check(bus.segments);
    sb_check(32'(bus.red_leds));
    step(1);
    sb_check(32'(bus.green_leds));

    // Pause landing just after prescaler moves to 1, at digit0 = 5.
    step(8);
    bus.key_run_n = 1'b0;
    sb_push("pause_run", 32'h0);
    sb_push("pause_seg", 32'h35);
    sb_push("pause_green", 32'h001F);
    step(7);
    sb_check(32'(bus.running));
    sb_check(bus.segments);
    step(1);
    sb_check(32'(bus.green_leds));
    step(2);
    bus.key_run_n = 1'b1;
    sb_push("paused_seg", 32'h35);
    sb_push("paused_green", 32'h001F);
    step(10);
    sb_check(bus.segments);
    sb_check(32'(bus.green_leds));

    // Resume: partial tick kept, so the tick lands two edges after resuming.
    bus.key_run_n = 1'b0;
    sb_push("resume_run", 32'h1);
    sb_push("resume_seg", 32'h35);
    sb_push("resume_hold", 32'h35);
    sb_push("resume_tick", 32'h36);
    step(7);
    sb_check(32'(bus.running));
    sb_check(bus.segments);
    step(1);
    sb_check(bus.segments);
    step(1);
    sb_check(bus.segments);
    step(1);
    bus.key_run_n = 1'b1;

    // Clear press that coincides with a tick edge.
    step(1);
    bus.key_clr_n = 1'b0;
    sb_push("pre_clr_seg", 32'h38);
    sb_push("clr_tick_seg", 32'h0);
    sb_push("clr_red", 32'h0001);
    sb_push("post_clr_tick", 32'h1);
    step(6);
    sb_check(bus.segments);
    step(1);
    sb_check(bus.segments);
    sb_check(32'(bus.red_leds));
    step(3);
    sb_check(bus.segments);
    bus.key_clr_n = 1'b1;

    // Preload all nines, then one tick wraps.
    force dut.seg_q = 32'h99999999;
    step(1);
    release dut.seg_q;
    sb_push("wrap_seg", 32'h0);
    sb_push("wrap_red", 32'h0004);
    sb_push("wrap_green", 32'hC000);
    step(2);
    sb_check(bus.segments);
    sb_check(32'(bus.red_leds));
    step(1);
    sb_check(32'(bus.green_leds));

    // Clear press drops the sticky wrap flag.
    step(4);
    bus.key_clr_n = 1'b0;
    sb_push("wrap_kept", 32'h1);
    sb_push("wrap_clr_seg", 32'h0);
    sb_push("wrap_cleared", 32'h0);
    step(7);
    sb_check(32'(bus.green_leds[14]));
    sb_check(bus.segments);
    step(1);
    sb_check(32'(bus.green_leds[14]));
    step(2);
    bus.key_clr_n = 1'b1;

    // Clear and run pressed together while running.
    step(7);
    bus.key_run_n = 1'b0;
    bus.key_clr_n = 1'b0;
    sb_push("both_pre_run", 32'h1);
    sb_push("both_pre_seg", 32'h5);
    sb_push("both_seg", 32'h0);
    sb_push("both_run", 32'h0);
    step(6);
    sb_check(32'(bus.running));
    sb_check(bus.segments);
    step(1);
    sb_check(bus.segments);
    sb_check(32'(bus.running));
    step(3);
    bus.key_run_n = 1'b1;
    bus.key_clr_n = 1'b1;
    step(12);

    // Asynchronous reset mid-count while running.
    bus.key_run_n = 1'b0;
    sb_push("rerun", 32'h1);
    step(7);
    sb_check(32'(bus.running));
    step(2);
    bus.key_run_n = 1'b1;
    force dut.seg_q = 32'h42;
    step(1);
    release dut.seg_q;
    #1;
    sb_push("pre_rst_seg", 32'h42);
    sb_check(bus.segments);
    #1;
    rst = 1'b1;
    #1;
    sb_push("arst_seg", 32'h0);
    sb_push("arst_red", 32'h0001);
    sb_push("arst_green", 32'h0);
    sb_push("arst_run", 32'h0);
    sb_check(bus.segments);
    sb_check(32'(bus.red_leds));
    sb_check(32'(bus.green_leds));
    sb_check(32'(bus.running));
    step(2);
    rst = 1'b0;
    sb_push("after_rst_seg", 32'h0);
    step(5);
    sb_check(bus.segments);

    if (exp_q.size() != 0) begin
      n_total++;
      n_bad++;
      $display("FAIL sb_leftover: got %0d entries want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
